// File: rtl/minmax_tracker_if.sv
// Bundles the frame control, sample stream and result handshake of the
// extremum tracker so the tracker and its driver share one connection point.
interface minmax_tracker_if #(
    parameter int W     = 32,
    parameter int CNT_W = 16
);

    logic             start;
    logic [CNT_W-1:0] len;
    logic             signed_mode;

    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_data;

    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     min;
    logic [W-1:0]     max;
    logic [CNT_W-1:0] min_idx;
    logic [CNT_W-1:0] max_idx;

    logic             busy;

    // Producer/consumer side: issues frames, supplies samples, takes results.
    modport master (
        output start,
        output len,
        output signed_mode,
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  min,
        input  max,
        input  min_idx,
        input  max_idx,
        input  busy
    );

    // Tracker side: accepts frames and samples, presents results.
    modport slave (
        input  start,
        input  len,
        input  signed_mode,
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output min,
        output max,
        output min_idx,
        output max_idx,
        output busy
    );

endinterface

// File: rtl/minmax_tracker.sv
// Streaming extremum tracker: walks a frame of samples and keeps the running
// minimum and maximum together with the index of the first occurrence of
// each, using signed or unsigned ordering chosen when the frame starts.
module minmax_tracker #(
    parameter int W     = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    minmax_tracker_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic             signed_q, signed_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     min_q, min_d;
    logic [W-1:0]     max_q, max_d;
    logic [CNT_W-1:0] min_idx_q, min_idx_d;
    logic [CNT_W-1:0] max_idx_q, max_idx_d;

    logic             accept;
    logic             last_sample;
    logic [W-1:0]     key_data;
    logic [W-1:0]     key_min;
    logic [W-1:0]     key_max;
    logic             data_lt_min;
    logic             data_gt_max;

    // A sample is consumed only while accumulating; the last one is the
    // sample whose index equals len-1, so the counter never needs to wrap.
    assign accept      = (state_q == ACCUM) && bus.in_valid;
    assign last_sample = (cnt_q == (len_q - CNT_W'(1)));

    // Ordering keys: flipping the MSB maps two's-complement order onto
    // unsigned order, so one magnitude comparator serves both modes.
    always_comb begin
        key_data = bus.in_data;
        key_min  = min_q;
        key_max  = max_q;
        if (signed_q) begin
            key_data[W-1] = ~bus.in_data[W-1];
            key_min[W-1]  = ~min_q[W-1];
            key_max[W-1]  = ~max_q[W-1];
        end
        data_lt_min = (key_data < key_min);
        data_gt_max = (key_data > key_max);
    end

    // Next-state and datapath update; strict comparisons keep the earliest
    // index on ties, and results stay untouched until a new sample lands.
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        signed_d  = signed_q;
        cnt_d     = cnt_q;
        min_d     = min_q;
        max_d     = max_q;
        min_idx_d = min_idx_q;
        max_idx_d = max_idx_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    len_d    = bus.len;
                    signed_d = bus.signed_mode;
                    cnt_d    = '0;
                    if (bus.len == '0) begin
                        state_d   = DONE;
                        min_d     = '0;
                        max_d     = '0;
                        min_idx_d = '0;
                        max_idx_d = '0;
                    end else begin
                        state_d = ACCUM;
                    end
                end
            end

            ACCUM: begin
                if (accept) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == '0) begin
                        min_d     = bus.in_data;
                        max_d     = bus.in_data;
                        min_idx_d = '0;
                        max_idx_d = '0;
                    end else begin
                        if (data_lt_min) begin
                            min_d     = bus.in_data;
                            min_idx_d = cnt_q;
                        end
                        if (data_gt_max) begin
                            max_d     = bus.in_data;
                            max_idx_d = cnt_q;
                        end
                    end
                    if (last_sample) begin
                        state_d = DONE;
                    end
                end
            end

            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any frame in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            len_q     <= '0;
            signed_q  <= 1'b0;
            cnt_q     <= '0;
            min_q     <= '0;
            max_q     <= '0;
            min_idx_q <= '0;
            max_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            signed_q  <= signed_d;
            cnt_q     <= cnt_d;
            min_q     <= min_d;
            max_q     <= max_d;
            min_idx_q <= min_idx_d;
            max_idx_q <= max_idx_d;
        end
    end

    // Handshake flags are pure decodes of the registered state.
    assign bus.in_ready  = (state_q == ACCUM);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.min       = min_q;
    assign bus.max       = max_q;
    assign bus.min_idx   = min_idx_q;
    assign bus.max_idx   = max_idx_q;

endmodule

// File: tb/tb_minmax_tracker.sv
// Self-checking bench for minmax_tracker: directed frames from the test plan
// plus randomized frames, compared against a queue-based reference model.
module tb_minmax_tracker;

    localparam int W     = 32;
    localparam int CNT_W = 16;

    logic clk;
    logic rst;

    int compared;
    int mismatched;

    logic [W-1:0]     expMin, expMax;
    logic [CNT_W-1:0] expMinIdx, expMaxIdx;

    minmax_tracker_if #(.W(W), .CNT_W(CNT_W)) bus ();

    minmax_tracker #(.W(W), .CNT_W(CNT_W)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts, and reports any disagreement.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
            $error("[TB] check %s did not match", tag);
        end
    endtask

    // Sort key of a sample in the chosen ordering, as a wide integer.
    function automatic longint orderKey(input logic [W-1:0] v, input bit sm);
        if (sm) return longint'(signed'(v));
        return longint'(v);
    endfunction

    // Reference: first occurrence of the smallest and largest sample.
    task automatic computeRef(input logic [W-1:0] s[$], input bit sm);
        longint minKey, maxKey, k;
        expMin = '0; expMax = '0; expMinIdx = '0; expMaxIdx = '0;
        minKey = 0; maxKey = 0;
        for (int i = 0; i < s.size(); i++) begin
            k = orderKey(s[i], sm);
            if (i == 0 || k < minKey) begin
                minKey = k; expMin = s[i]; expMinIdx = CNT_W'(i);
            end
            if (i == 0 || k > maxKey) begin
                maxKey = k; expMax = s[i]; expMaxIdx = CNT_W'(i);
            end
        end
    endtask

    function automatic logic [W-1:0] pickSample();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0007;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic checkResults(input string tag);
        checkOutput({tag, ".min"}, 64'(bus.min), 64'(expMin));
        checkOutput({tag, ".max"}, 64'(bus.max), 64'(expMax));
        checkOutput({tag, ".min_idx"}, 64'(bus.min_idx), 64'(expMinIdx));
        checkOutput({tag, ".max_idx"}, 64'(bus.max_idx), 64'(expMaxIdx));
    endtask

    // Caller sits just after a rising edge; start is taken at the next edge.
    task automatic startFrame(input int n, input bit sm);
        bus.start       = 1'b1;
        bus.len         = CNT_W'(n);
        bus.signed_mode = sm;
        @(posedge clk); #1;
        bus.start       = 1'b0;
        bus.len         = CNT_W'($urandom);
        bus.signed_mode = 1'($urandom);
        if (n == 0) begin
            checkOutput("start0.out_valid", 64'(bus.out_valid), 64'd1);
        end else begin
            checkOutput("start.busy", 64'(bus.busy), 64'd1);
            checkOutput("start.in_ready", 64'(bus.in_ready), 64'd1);
        end
    endtask

    // Feed samples with random idle gaps; optional start pokes in the gaps.
    task automatic applyStimulus(input logic [W-1:0] s[$], input int gapPct,
                                 input bit poke, input bit expectDone);
        for (int i = 0; i < s.size(); i++) begin
            for (int g = 0; g < 3; g++) begin
                if ($urandom_range(0, 99) >= gapPct) break;
                bus.in_valid = 1'b0;
                bus.in_data  = $urandom;
                bus.start    = poke;
                @(posedge clk); #1;
                bus.start    = 1'b0;
                checkOutput("gap.in_ready", 64'(bus.in_ready), 64'd1);
            end
            bus.in_valid = 1'b1;
            bus.in_data  = s[i];
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        bus.in_data  = $urandom;
        if (expectDone) begin
            checkOutput("last.out_valid", 64'(bus.out_valid), 64'd1);
            checkOutput("last.in_ready", 64'(bus.in_ready), 64'd0);
        end
    endtask

    // Hold off the result, then accept it (optionally with a start pulse).
    task automatic collectResult(input int hold, input bit poke);
        for (int h = 0; h < hold; h++) begin
            bus.start = poke;
            @(posedge clk); #1;
            bus.start = 1'b0;
            checkOutput("hold.out_valid", 64'(bus.out_valid), 64'd1);
            checkResults("hold");
        end
        checkResults("result");
        bus.out_ready = 1'b1;
        bus.start     = poke;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        bus.start     = 1'b0;
        checkOutput("ack.out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("ack.busy", 64'(bus.busy), 64'd0);
    endtask

    task automatic runFrame(input logic [W-1:0] s[$], input bit sm, input int gapPct,
                            input int hold, input bit poke);
        logic [W-1:0] prevMin;
        prevMin = expMin;
        startFrame(s.size(), sm);
        if (s.size() != 0) checkOutput("held.min", 64'(bus.min), 64'(prevMin));
        computeRef(s, sm);
        if (s.size() != 0) applyStimulus(s, gapPct, poke, 1'b1);
        collectResult(hold, poke);
    endtask

    initial begin
        logic [W-1:0] q[$];
        compared   = 0;
        mismatched = 0;
        bus.start = 1'b0; bus.len = '0; bus.signed_mode = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
        rst = 1'b1;
        #12;
        expMin = '0; expMax = '0; expMinIdx = '0; expMaxIdx = '0;
        checkOutput("reset.busy", 64'(bus.busy), 64'd0);
        checkOutput("reset.in_ready", 64'(bus.in_ready), 64'd0);
        checkOutput("reset.out_valid", 64'(bus.out_valid), 64'd0);
        checkResults("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        $display("[TB] unsigned frame");
        q = '{32'd5, 32'd2, 32'd9, 32'd2};
        runFrame(q, 1'b0, 0, 0, 1'b0);
        checkOutput("uns.min_const", 64'(expMin), 64'd2);

        $display("[TB] signed frame and its unsigned repeat");
        q = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
        runFrame(q, 1'b1, 0, 1, 1'b0);
        runFrame(q, 1'b0, 0, 1, 1'b0);

        $display("[TB] zero length and ties");
        q.delete();
        runFrame(q, 1'b0, 0, 1, 1'b0);
        q = '{32'd7, 32'd7, 32'd7};
        runFrame(q, 1'b1, 0, 0, 1'b0);

        $display("[TB] backpressure with ignored starts");
        q = '{32'd3, 32'h8000_0000, 32'd0, 32'hFFFF_FFFE, 32'd3, 32'h8000_0000};
        runFrame(q, 1'b1, 60, 5, 1'b1);

        $display("[TB] randomized frames");
        for (int f = 0; f < 8; f++) begin
            q.delete();
            for (int i = 0; i < $urandom_range(1, 12); i++) q.push_back(pickSample());
            runFrame(q, 1'($urandom), 30, $urandom_range(0, 5), 1'($urandom));
        end

        $display("[TB] reset mid-frame");
        q = '{32'd4, 32'd8};
        startFrame(4, 1'b0);
        applyStimulus(q, 0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        expMin = '0; expMax = '0; expMinIdx = '0; expMaxIdx = '0;
        checkOutput("midrst.busy", 64'(bus.busy), 64'd0);
        checkOutput("midrst.in_ready", 64'(bus.in_ready), 64'd0);
        checkOutput("midrst.out_valid", 64'(bus.out_valid), 64'd0);
        checkResults("midrst");
        @(posedge clk); #1;
        rst = 1'b0;
        q = '{32'h0000_000A};
        runFrame(q, 1'b0, 0, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
